offchip_link_arbiter: RTL
=========================

// Module: offchip_link_arbiter
// PURPOSE
//   Shares the single 64-bit off-chip link (valid_in/data_in/ready stream) between NUM_REQ on-chip requesters.
//   Round-robin arbitration with burst locking: a granted requester owns the link until its last beat,
//   until MAX_BURST beats have been sent, or until it drops valid.
//   Sits directly in front of the off-chip interface block.
//   Drives that block's valid_in/data_in from a one-entry output register and obeys its ready.
// PARAMETERS
//   NUM_REQ    4   number of requesters, >=2
//   DATA_W     64  beat width, matches the off-chip link
//   MAX_BURST  8   max beats per grant before forced rotation, >=1
// PORTS
//   clk        in   1                 clock, all state on rising edge
//   rst        in   1                 asynchronous, active-high reset
//   req_valid  in   NUM_REQ           per-requester beat valid
//   req_last   in   NUM_REQ           per-requester last beat of burst
//   req_data   in   NUM_REQ*DATA_W    packed beats, requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  NUM_REQ           per-requester accept, one-hot or zero
//   valid_out  out  1                 beat valid toward off-chip link
//   data_out   out  DATA_W            beat toward off-chip link
//   ready      in   1                 off-chip link accepts beat
//   grant_id   out  $clog2(NUM_REQ)   current or last owner index
//   busy       out  1                 1 while in BURST state
// BEHAVIOUR
//   Reset values: valid_out=0, data_out=0, req_ready=0, grant_id=0, busy=0, state=IDLE, beat_cnt=0.
//   Reset also sets last_grant=NUM_REQ-1, so requester 0 wins the first arbitration.
//   Reset mid-burst: all state clears immediately; a beat held in the output register is discarded.
//   Output register: free = !valid_out || ready.
//     Capture sets valid_out=1 and loads data_out.
//     If ready with no capture, valid_out=0.
//     With ready=0, data_out and valid_out hold stable.
//   FSM IDLE:
//     - If any req_valid, winner = first set bit searching from (last_grant+1) mod NUM_REQ upward, wrapping.
//     - Winner is registered into grant_id, beat_cnt=0, next state BURST.
//     - req_ready=0 in IDLE: one-cycle arbitration bubble per grant.
//   FSM BURST, g=grant_id:
//     - req_ready[g] = free; all other req_ready bits = 0.
//     - Transfer = req_valid[g] && req_ready[g]. It loads data_out next edge and increments beat_cnt.
//     - Exit to IDLE (last_grant<=g) on a transfer with req_last[g]=1, or on a transfer with beat_cnt==MAX_BURST-1.
//     - Also exit to IDLE when req_valid[g]=0. A requester with a gap loses the grant.
//   Latency: req_valid rises at cycle T in IDLE -> req_ready at T+1 (if free) -> valid_out at T+2.
//   Throughput: 1 beat/cycle inside a burst; 1 bubble between bursts.
//   Simultaneous events:
//     - Capture and downstream accept in the same cycle keep valid_out=1 with the new data.
//     - A request from the just-released owner while others wait loses to the next index.
//   Only the granted requester's valid/last/data are observed; other inputs are ignored.
// CONFIGURATION
//   OFFCHIP_ARB_PERF_EN defined: adds two output ports.
//     - perf_beats[31:0] counts cycles with valid_out && ready.
//     - perf_stall[31:0] counts cycles with valid_out && !ready.
//     - Both saturate at 32'hFFFF_FFFF and reset to 0.
//   OFFCHIP_ARB_PERF_EN undefined: these ports and counters are absent. All other behaviour is identical.
// TESTING
//   1. Reset state: assert rst with all inputs active -> valid_out=0, req_ready=0, busy=0, grant_id=0 while rst=1.
//   2. Single burst: req 2 sends 3 beats A0,A1,A2 (last on A2), ready=1.
//      -> data_out shows A0,A1,A2 on consecutive cycles starting 2 cycles after req_valid.
//      -> Then busy=0, and grant_id stays 2.
//   3. Round robin: reqs 0,1,3 each hold single-beat bursts continuously.
//      -> Grant order is 0,1,3,0,1,3; requester 2 never gets req_ready.
//   4. MAX_BURST=8: req 1 sends 20 beats with no last, req 0 also valid.
//      -> After 8 beats grant goes to req 0 (rotation 1->...->0), then returns to req 1.
//   5. Backpressure: ready=0 for 5 cycles mid-burst -> data_out/valid_out hold stable.
//      -> req_ready[g]=0 after the register fills; no beat is lost or duplicated once ready returns.
//   6. Reset mid-burst: assert rst on beat 3 of 5 -> outputs clear at once.
//      -> After release, requester 0 is granted first if valid. With OFFCHIP_ARB_PERF_EN, perf_beats=0.

Source files
------------

// File: rtl/offchip_link_arbiter.sv
// -----------------------------------------------------------------------------
// offchip_link_arbiter
//
// Purpose:
//   Shares one off-chip beat link between NUM_REQ on-chip requesters.
//   Round-robin arbitration with burst locking. The owner keeps the link until
//   one of three things happens: it sends its last beat, it has sent MAX_BURST
//   beats, or it drops valid. Beats toward the link come from a one-entry
//   output register that obeys the link's ready.
//
// Parameters:
//   NUM_REQ   number of requesters (>=2)
//   DATA_W    beat width
//   MAX_BURST beats per grant before forced rotation (>=1)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NUM_REQ]          per-requester beat valid
//   req_last   in   [NUM_REQ]          per-requester last beat of burst
//   req_data   in   [NUM_REQ*DATA_W]   packed beats, requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  [NUM_REQ]          per-requester accept (one-hot or zero)
//   valid_out  out                     beat valid toward the link
//   data_out   out  [DATA_W]           beat toward the link
//   ready      in                      link accepts beat
//   grant_id   out  [clog2(NUM_REQ)]   current or most recent owner
//   busy       out                     high while a burst owns the link
//   perf_beats out  [32]               (OFFCHIP_ARB_PERF_EN only) accepted-beat cycles
//   perf_stall out  [32]               (OFFCHIP_ARB_PERF_EN only) stalled-beat cycles
//
// Build option:
//   OFFCHIP_ARB_PERF_EN  adds the saturating perf_beats/perf_stall counters.
// -----------------------------------------------------------------------------
module offchip_link_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 64,
   parameter int MAX_BURST = 8,
   localparam int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_last,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        valid_out,
   output logic [DATA_W-1:0]           data_out,
   input  logic                        ready,
   output logic [GW-1:0]               grant_id,
   output logic                        busy
`ifdef OFFCHIP_ARB_PERF_EN
   ,
   output logic [31:0]                 perf_beats,
   output logic [31:0]                 perf_stall
`endif
);

   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       last_q, last_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                vld_q, vld_d;
   logic [DATA_W-1:0]   data_q, data_d;

   logic                free;
   logic                xfer;
   logic                found;
   logic [GW-1:0]       cand;
   logic [GW-1:0]       winner;

   // The output register can take a new beat when empty or draining this cycle.
   assign free = !vld_q || ready;

   // Round-robin search starting just after the previous owner, so a
   // just-released owner is considered last.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = GW'((int'(last_q) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      vld_d     = vld_q;
      data_d    = data_q;
      req_ready = '0;
      xfer      = 1'b0;

      case (state_q)
         IDLE: begin
            // One-cycle arbitration bubble: nobody is acknowledged here.
            if (found) begin
               grant_d = winner;
               cnt_d   = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            req_ready[grant_q] = free;
            xfer               = req_valid[grant_q] && free;
            if (!req_valid[grant_q]) begin
               // A gap in the owner's stream forfeits the grant.
               state_d = IDLE;
               last_d  = grant_q;
            end else if (xfer) begin
               if (req_last[grant_q] || (cnt_q == CW'(MAX_BURST - 1))) begin
                  state_d = IDLE;
                  last_d  = grant_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Capture wins over drain, so capture+accept keeps valid high with new data.
      if (xfer) begin
         vld_d  = 1'b1;
         data_d = req_data[grant_q*DATA_W +: DATA_W];
      end else if (ready) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GW'(NUM_REQ - 1);
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
      end
   end

   assign valid_out = vld_q;
   assign data_out  = data_q;
   assign grant_id  = grant_q;
   assign busy      = (state_q == BURST);

`ifdef OFFCHIP_ARB_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] perf_beats_q, perf_beats_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_beats_d = perf_beats_q;
      perf_stall_d = perf_stall_q;
      if (vld_q && ready)  perf_beats_d = sat_inc(perf_beats_q);
      if (vld_q && !ready) perf_stall_d = sat_inc(perf_stall_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_beats_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_beats_q <= perf_beats_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_beats = perf_beats_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule
